mem_io_stage: RTL and testbench
===============================

// Module: mem_io_stage
// PURPOSE
//  Memory/IO stage directly downstream of the execute stage. It takes the instructions that execute
//  does not retire itself (load, store, in, out), runs them against the data BRAM or the byte-wide
//  UART FIFOs, and produces the writeback pulse and data for the register file. busy stalls upstream.
// PARAMETERS
//  ADDR_W   17  BRAM word-address width; mem_addr[ADDR_W-1:0] used, word addressed
//  MEM_LAT  2   BRAM read latency in clock edges (address present -> bram_dout valid), >=1
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rstn        in   1       asynchronous active-low reset
//  stage_en    in   1       1-cycle start pulse from execute; sampled only when busy==0
//  mem_access  in   1       op is load/store
//  mem_we      in   1       with mem_access: 1=store, 0=load
//  in_en       in   1       op is IN (read one byte from input FIFO)
//  out_en      in   1       op is OUT (write one byte to output FIFO)
//  is_float    in   1       load/in result targets float register file
//  mem_addr    in   32      address (execute dout)
//  mem_wdata   in   32      store data / out byte in [7:0]
//  bram_addr   out  ADDR_W  BRAM address (registered)
//  bram_din    out  32      BRAM write data (registered)
//  bram_we     out  1       BRAM write strobe
//  bram_dout   in   32      BRAM read data
//  in_data     in   8       input FIFO byte
//  in_valid    in   1       input FIFO has data
//  in_ready    out  1       stage accepts in_data
//  out_data    out  8       output byte
//  out_valid   out  1       output byte offered
//  out_ready   in   1       output FIFO accepts
//  wb_en       out  1       1-cycle writeback pulse
//  wb_data     out  32      writeback value
//  wb_float    out  1       wb_data targets float regfile
//  busy        out  1       stage occupied; upstream must hold
//  addr_err    out  1       only with MEM_ADDR_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rstn=0): state IDLE; every output 0; pending handshake dropped, nothing retried.
//  - FSM: IDLE, LOAD_WAIT, STORE, IN_WAIT, OUT_WAIT, WB. busy = (state != IDLE).
//  - IDLE & stage_en at cycle T. Exactly one of mem_access/in_en/out_en is 1; if none, ignored.
//    mem_addr, mem_wdata and is_float are latched at the end of T.
//  - Store: bram_addr/bram_din registered; bram_we=1 during T+1 only (STORE); back in IDLE at T+2.
//    No wb_en.
//  - Load: bram_addr registered, state LOAD_WAIT; the counter loads MEM_LAT; bram_dout captured at
//    the end of T+1+MEM_LAT; WB: wb_en=1 in T+2+MEM_LAT; IDLE in the next cycle.
//  - IN: in_ready=1 throughout IN_WAIT (from T+1). The byte is captured on the first cycle with
//    in_valid&in_ready; wb_data={24'b0,in_data}; wb_en the following cycle. Waits indefinitely.
//  - OUT: out_valid=1, out_data=mem_wdata[7:0], both held stable from T+1 until out_ready.
//    IDLE the cycle after the handshake. No wb_en. Waits indefinitely.
//  - wb_data/wb_float hold their last value between pulses; wb_en is never high 2 consecutive cycles.
//  - stage_en while busy: protocol violation, ignored (no state change).
//  - A new stage_en is accepted in the first IDLE cycle after completion, giving back-to-back ops.
// CONFIGURATION
//  MEM_ADDR_CHECK_EN defined: a load/store with mem_addr[31:ADDR_W]!=0 sets addr_err=1 (sticky
//    until reset). A faulting store suppresses bram_we. A faulting load still pulses wb_en with
//    wb_data=0, same latency.
//  Not defined: addr_err tied 0; upper address bits ignored (wrap-around in BRAM).
// STRUCTURE
//  - Shared def.vh header: state encodings (ST_IDLE..ST_WB), MEM_LAT default.
//  - One sub-module, mem_wait_counter: loadable down-counter, done when it reaches 0.
//  - Everything else stays inline.
// TESTING
//  - Load, MEM_LAT=2: BRAM[5]=0xDEADBEEF, stage_en with addr 5 at T -> wb_en only in T+4,
//    wb_data=0xDEADBEEF, busy high T+1..T+4.
//  - Store then load same addr 9, data 0x3F800000 is_float=1 -> bram_we 1 cycle;
//    load returns 0x3F800000 with wb_float=1.
//  - IN, in_valid delayed 5 cycles, byte 0x41 -> wb_data=0x00000041 the cycle after the handshake;
//    busy throughout.
//  - OUT 0x5A, out_ready low 3 cycles -> out_valid/out_data stable; drops the cycle after
//    out_ready=1; no wb_en.
//  - rstn low during LOAD_WAIT -> immediate IDLE, outputs 0, no wb_en afterwards.
//    The next load works normally.
//  - MEM_ADDR_CHECK_EN: store to 0x00020000 (ADDR_W=17) -> addr_err=1, bram_we stays 0.

Source files
------------

// File: rtl/mem_io_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_io_stage_pkg
// Shared definitions for the memory/IO stage:
//   - ADDR_W_DEFAULT / MEM_LAT_DEFAULT : default BRAM address width and read latency
//   - state_t                          : FSM state encodings (ST_IDLE .. ST_WB)
//   - cnt_width()                      : width of the latency down-counter
// -----------------------------------------------------------------------------
package mem_io_stage_pkg;

    localparam int ADDR_W_DEFAULT  = 17;
    localparam int MEM_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_WAIT = 3'd1,
        ST_STORE     = 3'd2,
        ST_IN_WAIT   = 3'd3,
        ST_OUT_WAIT  = 3'd4,
        ST_WB        = 3'd5
    } state_t;

    // Bits needed to hold the values 0..lat (at least one bit).
    function automatic int cnt_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_io_stage_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Loadable down-counter used to time the BRAM read latency. done_o is high
// whenever the count is zero; the counter stops at zero.
// Ports:
//   clk_i       clock
//   rstn_i      asynchronous active-low reset
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one (ignored at zero)
//   done_o      count is zero
// -----------------------------------------------------------------------------
module mem_wait_counter #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_io_stage.sv
// -----------------------------------------------------------------------------
// mem_io_stage
// Memory/IO stage after execute. Runs load/store against the data BRAM and
// IN/OUT against byte-wide FIFOs, then produces a one-cycle register-file
// writeback pulse. busy holds the upstream pipeline while an op is in flight.
//
// Optional feature: define MEM_ADDR_CHECK_EN to flag load/store addresses with
// non-zero bits above ADDR_W (sticky addr_err, store suppressed, load returns 0).
// Without it addr_err stays 0 and the upper address bits wrap into the BRAM.
//
// Handshakes (in_valid/in_ready, out_valid/out_ready): a byte transfers on a
// rising edge where valid and ready are both high; the offering side holds
// valid and data stable until that edge and never withdraws early.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   stage_en                   start pulse, sampled only in IDLE
//   mem_access/mem_we          load (we=0) or store (we=1)
//   in_en / out_en             IN / OUT byte op
//   is_float                   load/IN result targets float regfile
//   mem_addr, mem_wdata        address, store data / OUT byte in [7:0]
//   bram_addr/bram_din/bram_we registered BRAM port; bram_dout read data
//   in_data/in_valid/in_ready  input FIFO side
//   out_data/out_valid/out_ready output FIFO side
//   wb_en/wb_data/wb_float     writeback pulse and value
//   busy                       stage occupied
//   addr_err                   sticky address fault (MEM_ADDR_CHECK_EN only)
//   dbg_state                  current FSM state
// -----------------------------------------------------------------------------
module mem_io_stage
    import mem_io_stage_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stage_en,
    input  logic              mem_access,
    input  logic              mem_we,
    input  logic              in_en,
    input  logic              out_en,
    input  logic              is_float,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic              bram_we,
    input  logic [31:0]       bram_dout,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic [31:0]       wb_data,
    output logic              wb_float,
    output logic              busy,
    output logic              addr_err,
    output state_t            dbg_state
);

    localparam int CNT_W = cnt_width(MEM_LAT);

    state_t              state_q;
    logic [ADDR_W-1:0]   bram_addr_q;
    logic [31:0]         bram_din_q;
    logic                bram_we_q;
    logic                in_ready_q;
    logic [7:0]          out_data_q;
    logic                out_valid_q;
    logic                wb_en_q;
    logic [31:0]         wb_data_q;
    logic                wb_float_q;
    logic                float_q;     // is_float latched at start
    logic                bad_q;       // current load/store address faulted
    logic                addr_err_q;

    logic                addr_bad;
    logic                start;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_done;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad = |mem_addr[31:ADDR_W];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:ADDR_W];
    assign addr_bad       = 1'b0;
`endif

    assign start    = (state_q == ST_IDLE) && stage_en;
    assign cnt_load = start && mem_access && !mem_we;
    // Hold at zero on the capture cycle so done stays asserted there.
    assign cnt_dec  = (state_q == ST_LOAD_WAIT) && !cnt_done;

    mem_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(MEM_LAT)),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_we_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_data_q   <= '0;
            wb_float_q  <= 1'b0;
            float_q     <= 1'b0;
            bad_q       <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            wb_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (stage_en) begin
                        float_q <= is_float;
                        if (mem_access) begin
                            bram_addr_q <= mem_addr[ADDR_W-1:0];
                            bad_q       <= addr_bad;
                            addr_err_q  <= addr_err_q | addr_bad;
                            if (mem_we) begin
                                bram_din_q <= mem_wdata;
                                bram_we_q  <= !addr_bad;
                                state_q    <= ST_STORE;
                            end else begin
                                state_q <= ST_LOAD_WAIT;
                            end
                        end else if (in_en) begin
                            in_ready_q <= 1'b1;
                            state_q    <= ST_IN_WAIT;
                        end else if (out_en) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= mem_wdata[7:0];
                            state_q     <= ST_OUT_WAIT;
                        end
                    end
                end
                ST_STORE: begin
                    bram_we_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                ST_LOAD_WAIT: begin
                    // done marks the cycle in which bram_dout is valid.
                    if (cnt_done) begin
                        wb_data_q  <= bad_q ? 32'h0 : bram_dout;
                        wb_float_q <= float_q;
                        wb_en_q    <= 1'b1;
                        state_q    <= ST_WB;
                    end
                end
                ST_IN_WAIT: begin
                    if (in_valid) begin
                        wb_data_q  <= {24'h0, in_data};
                        wb_float_q <= float_q;
                        wb_en_q    <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_WB;
                    end
                end
                ST_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign bram_we   = bram_we_q;
    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign wb_en     = wb_en_q;
    assign wb_data   = wb_data_q;
    assign wb_float  = wb_float_q;
    assign busy      = (state_q != ST_IDLE);
    assign addr_err  = addr_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_io_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_io_stage
// Directed bench for mem_io_stage with a behavioural two-cycle-latency BRAM.
// Cycle convention: inputs are driven and outputs sampled 1 time unit after
// the rising edge that starts a cycle.
// -----------------------------------------------------------------------------
module tb_mem_io_stage;
    import mem_io_stage_pkg::*;

    localparam int ADDR_W  = 17;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic              stage_en, mem_access, mem_we, in_en, out_en, is_float;
    logic [31:0]       mem_addr, mem_wdata;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic              bram_we;
    logic [31:0]       bram_dout;
    logic [7:0]        in_data;
    logic              in_valid, in_ready;
    logic [7:0]        out_data;
    logic              out_valid, out_ready;
    logic              wb_en;
    logic [31:0]       wb_data;
    logic              wb_float, busy, addr_err;
    state_t            dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    mem_io_stage #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rstn(rstn), .stage_en(stage_en), .mem_access(mem_access),
        .mem_we(mem_we), .in_en(in_en), .out_en(out_en), .is_float(is_float),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_we(bram_we), .bram_dout(bram_dout),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .wb_en(wb_en), .wb_data(wb_data), .wb_float(wb_float), .busy(busy),
        .addr_err(addr_err), .dbg_state(dbg_state)
    );

    // ---------------- BRAM model (2-edge read latency) ----------------
    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bram_we) mem[bram_addr[7:0]] <= bram_din;
        rd_pipe   <= mem[bram_addr[7:0]];
        bram_dout <= rd_pipe;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives a start pulse in the current cycle T and returns in cycle T+1.
    task automatic issue(input logic a_acc, input logic a_we, input logic a_in,
                         input logic a_out, input logic a_flt,
                         input logic [31:0] a_addr, input logic [31:0] a_wdata);
        stage_en   = 1'b1;
        mem_access = a_acc;
        mem_we     = a_we;
        in_en      = a_in;
        out_en     = a_out;
        is_float   = a_flt;
        mem_addr   = a_addr;
        mem_wdata  = a_wdata;
        tick();
        stage_en   = 1'b0;
        mem_access = 1'b0;
        mem_we     = 1'b0;
        in_en      = 1'b0;
        out_en     = 1'b0;
        is_float   = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn = 1'b0;
        stage_en = 1'b0; mem_access = 1'b0; mem_we = 1'b0; in_en = 1'b0;
        out_en = 1'b0; is_float = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        in_data = 8'h0; in_valid = 1'b0; out_ready = 1'b0;
        pre_we = 1'b1; pre_addr = 8'd5; pre_data = 32'hDEADBEEF;
        tick();
        pre_we = 1'b0;

        // Reset state
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_wb_en",     32'(wb_en),     32'h0);
        chk("rst_wb_data",   wb_data,        32'h0);
        chk("rst_bram_we",   32'(bram_we),   32'h0);
        chk("rst_bram_addr", 32'(bram_addr), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_addr_err",  32'(addr_err),  32'h0);
        chk("rst_state",     32'(dbg_state), 32'(ST_IDLE));
        rstn = 1'b1;
        tick();

        // stage_en with no op selected is ignored
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0);
        chk("noop_busy", 32'(busy), 32'h0);

        // Load addr 5: wb_en only in T+4, busy T+1..T+4; a start while busy is ignored
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("ld_wb_en_t%0d", k), 32'(wb_en), 32'(k == 4));
            chk($sformatf("ld_busy_t%0d", k),  32'(busy),  32'(k <= 4));
            chk($sformatf("ld_oval_t%0d", k),  32'(out_valid), 32'h0);
            if (k == 1) begin
                chk("ld_bram_addr", 32'(bram_addr), 32'h5);
                chk("ld_state",     32'(dbg_state), 32'(ST_LOAD_WAIT));
                stage_en = 1'b1; out_en = 1'b1; mem_wdata = 32'h77;
            end
            if (k == 2) begin
                stage_en = 1'b0; out_en = 1'b0; mem_wdata = 32'h0;
            end
            if (k == 4) begin
                chk("ld_wb_data",  wb_data,        32'hDEADBEEF);
                chk("ld_wb_float", 32'(wb_float),  32'h0);
            end
            tick();
        end

        // Store 0x3F800000 to 9, then load it back-to-back as float
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h9, 32'h3F800000);
        chk("st_bram_we",   32'(bram_we),   32'h1);
        chk("st_bram_addr", 32'(bram_addr), 32'h9);
        chk("st_bram_din",  bram_din,       32'h3F800000);
        chk("st_state",     32'(dbg_state), 32'(ST_STORE));
        tick();
        chk("st_we_drop",   32'(bram_we),   32'h0);
        chk("st_idle",      32'(busy),      32'h0);
        chk("st_no_wb",     32'(wb_en),     32'h0);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h9, 32'h0);
        chk("ldf_busy", 32'(busy), 32'h1);
        tick(); tick();
        chk("ldf_wb_early", 32'(wb_en), 32'h0);
        tick();
        chk("ldf_wb_en",    32'(wb_en),    32'h1);
        chk("ldf_wb_data",  wb_data,       32'h3F800000);
        chk("ldf_wb_float", 32'(wb_float), 32'h1);
        tick();
        chk("ldf_wb_drop",  32'(wb_en),    32'h0);
        chk("ldf_idle",     32'(busy),     32'h0);
        chk("ldf_hold",     wb_data,       32'h3F800000);

        // IN with in_valid delayed 5 cycles, byte 0x41
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("in_rdy_t%0d", k),  32'(in_ready), 32'h1);
            chk($sformatf("in_busy_t%0d", k), 32'(busy),     32'h1);
            chk($sformatf("in_wb_t%0d", k),   32'(wb_en),    32'h0);
            tick();
        end
        in_valid = 1'b1; in_data = 8'h41;
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        chk("in_wb_en",    32'(wb_en),    32'h1);
        chk("in_wb_data",  wb_data,       32'h00000041);
        chk("in_wb_float", 32'(wb_float), 32'h0);
        chk("in_busy_wb",  32'(busy),     32'h1);
        chk("in_rdy_drop", 32'(in_ready), 32'h0);
        tick();
        chk("in_wb_drop",  32'(wb_en),    32'h0);
        chk("in_idle",     32'(busy),     32'h0);

        // OUT 0x5A with out_ready low for 3 cycles
        issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234565A);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("out_val_t%0d", k),  32'(out_valid), 32'h1);
            chk($sformatf("out_data_t%0d", k), 32'(out_data),  32'h5A);
            chk($sformatf("out_wb_t%0d", k),   32'(wb_en),     32'h0);
            chk($sformatf("out_busy_t%0d", k), 32'(busy),      32'h1);
            if (k == 3) out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("out_val_drop", 32'(out_valid), 32'h0);
        chk("out_idle",     32'(busy),      32'h0);
        chk("out_no_wb",    32'(wb_en),     32'h0);

        // Reset during LOAD_WAIT, then a normal load
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0);
        tick();
        chk("rl_state_wait", 32'(dbg_state), 32'(ST_LOAD_WAIT));
        rstn = 1'b0;
        #1;
        chk("rl_busy",      32'(busy),      32'h0);
        chk("rl_state",     32'(dbg_state), 32'(ST_IDLE));
        chk("rl_bram_addr", 32'(bram_addr), 32'h0);
        chk("rl_wb_data",   wb_data,        32'h0);
        tick();
        rstn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("rl_no_wb_%0d", k), 32'(wb_en), 32'h0);
            tick();
        end
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0);
        tick(); tick(); tick();
        chk("rl2_wb_en",   32'(wb_en), 32'h1);
        chk("rl2_wb_data", wb_data,    32'hDEADBEEF);
        tick();
        chk("rl2_idle",    32'(busy),  32'h0);

        // Out-of-range store address
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00020000, 32'h11111111);
`ifdef MEM_ADDR_CHECK_EN
        chk("ae_bram_we",  32'(bram_we),  32'h0);
        chk("ae_addr_err", 32'(addr_err), 32'h1);
        tick();
        chk("ae_sticky",   32'(addr_err), 32'h1);
        chk("ae_idle",     32'(busy),     32'h0);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00020005, 32'h0);
        tick(); tick(); tick();
        chk("ae_ld_wb_en",   32'(wb_en), 32'h1);
        chk("ae_ld_wb_data", wb_data,    32'h0);
        tick();
`else
        chk("wrap_bram_we",   32'(bram_we),   32'h1);
        chk("wrap_bram_addr", 32'(bram_addr), 32'h0);
        chk("wrap_addr_err",  32'(addr_err),  32'h0);
        tick();
        chk("wrap_idle",      32'(busy),      32'h0);
        chk("wrap_err_low",   32'(addr_err),  32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
